// File: rtl/feistel_pkg.sv
// Shared types and helpers for the iterative Feistel engine: FSM state encoding,
// a width-parametrised rotate-left and the block-width helper.
package feistel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest half-block the rotate helper can carry.
  localparam int unsigned ROT_MAX_W = 64;

  function automatic int unsigned blk_width(input int unsigned half_w);
    return 32'd2 * half_w;
  endfunction

  // Rotate the low w bits of x left by n (mod w); bits above w come back as zero.
  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] x,
                                                input int unsigned w,
                                                input int unsigned n);
    logic [ROT_MAX_W-1:0] mask;
    int unsigned s;
    s    = n % w;
    mask = (w >= ROT_MAX_W) ? {ROT_MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
    return ((x << s) | ((x & mask) >> (w - s))) & mask;
  endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational Feistel round: selects the round key for the current index and
// direction, evaluates F(x,k) = rotl(x ^ k, FROT) + k and performs the half swap.
module feistel_round #(
  parameter int unsigned HALF_W = 32,
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned FROT   = 3,
  parameter int unsigned KROT   = 1,
  parameter int unsigned CNT_W  = 5
) (
  input  logic [HALF_W-1:0] l,
  input  logic [HALF_W-1:0] r,
  input  logic [HALF_W-1:0] key,
  input  logic [CNT_W-1:0]  idx,
  input  logic              mode,
  output logic [HALF_W-1:0] l_n,
  output logic [HALF_W-1:0] r_n
);
  import feistel_pkg::*;

  int unsigned       sel_s;
  int unsigned       amt_s;
  logic [HALF_W-1:0] k_s;
  logic [HALF_W-1:0] f_s;

  // Decryption walks the key schedule backwards so the same round structure inverts it.
  always_comb begin
    sel_s = 32'd0;
    amt_s = 32'd0;
    k_s   = {HALF_W{1'b0}};
    f_s   = {HALF_W{1'b0}};
    sel_s = mode ? (ROUNDS - 32'd1 - 32'(idx)) : 32'(idx);
    amt_s = (sel_s * KROT) % HALF_W;
    k_s   = HALF_W'(rotl(64'(key), HALF_W, amt_s));
    f_s   = HALF_W'(rotl(64'(r ^ k_s), HALF_W, FROT % HALF_W)) + k_s;
    l_n   = r;
    r_n   = l ^ f_s;
  end

endmodule

// File: rtl/feistel_iter_core.sv
// Iterative Feistel cipher core, one round per clock, with valid/ready on both sides.
// Optional build macro FEISTEL_ZEROIZE_EN clears key/data state after each result is taken.
module feistel_iter_core #(
  parameter int unsigned HALF_W = 32,
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned FROT   = 3,
  parameter int unsigned KROT   = 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [HALF_W-1:0]   in_key,
  input  logic [2*HALF_W-1:0] in_block,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] out_block,
  output logic                busy
);
  import feistel_pkg::*;

  localparam int unsigned      BLK_W    = blk_width(HALF_W);
  localparam int unsigned      CNT_W    = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  if (ROUNDS < 1) begin : g_bad_rounds
    $error("feistel_iter_core: ROUNDS must be at least 1");
  end
  if ((HALF_W < 1) || (HALF_W > ROT_MAX_W)) begin : g_bad_width
    $error("feistel_iter_core: HALF_W out of range");
  end

  state_t            state_r, state_n;
  logic              accept_s, last_s;
  logic              mode_r;
  logic [HALF_W-1:0] key_r, l_r, r_r, l_n_s, r_n_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [BLK_W-1:0]  out_block_r;
  logic              in_ready_r, out_valid_r, busy_r;

  feistel_round #(
    .HALF_W(HALF_W), .ROUNDS(ROUNDS), .FROT(FROT), .KROT(KROT), .CNT_W(CNT_W)
  ) u_round (
    .l(l_r), .r(r_r), .key(key_r), .idx(cnt_r), .mode(mode_r), .l_n(l_n_s), .r_n(r_n_s)
  );

  // Next-state logic; inputs are only looked at in IDLE, out_ready only in DONE.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_n  = RUN;
        end else begin
          state_n  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_IDX) begin
          last_s  = 1'b1;
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and the handshake/status flags it decodes to.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      in_ready_r  <= (state_n == IDLE);
      out_valid_r <= (state_n == DONE);
      busy_r      <= (state_n == RUN);
    end
  end

  // Datapath: capture on accept, one round per RUN cycle, result latched on the last round.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      mode_r      <= 1'b0;
      key_r       <= {HALF_W{1'b0}};
      l_r         <= {HALF_W{1'b0}};
      r_r         <= {HALF_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_block_r <= {BLK_W{1'b0}};
    end else if (accept_s) begin
      mode_r <= in_mode;
      key_r  <= in_key;
      l_r    <= in_block[BLK_W-1:HALF_W];
      r_r    <= in_block[HALF_W-1:0];
      cnt_r  <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      l_r   <= l_n_s;
      r_r   <= r_n_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last_s) begin
        out_block_r <= {r_n_s, l_n_s};
      end
`ifdef FEISTEL_ZEROIZE_EN
    end else if ((state_r == DONE) && out_ready) begin
      key_r <= {HALF_W{1'b0}};
      l_r   <= {HALF_W{1'b0}};
      r_r   <= {HALF_W{1'b0}};
    end else if (state_r == IDLE) begin
      out_block_r <= {BLK_W{1'b0}};
`endif
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
`ifdef FEISTEL_ZEROIZE_EN
  assign out_block = out_valid_r ? out_block_r : {BLK_W{1'b0}};
`else
  assign out_block = out_block_r;
`endif

endmodule

// File: tb/tb_feistel_iter_core.sv
// Self-checking bench: a small 8-bit/1-round instance for known answers and a default
// instance for model-checked round trips, backpressure and mid-run reset.
module tb_feistel_iter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_busy;
  logic [7:0]  s_in_key;
  logic [15:0] s_in_block, s_out_block;
  logic        d_in_valid, d_in_ready, d_in_mode, d_out_valid, d_out_ready, d_busy;
  logic [31:0] d_in_key;
  logic [63:0] d_in_block, d_out_block;

  int vecs = 0;
  int errs = 0;
  logic [15:0] exp_s_q[$];
  logic [63:0] exp_d_q[$];

  feistel_iter_core #(.HALF_W(8), .ROUNDS(1), .FROT(3), .KROT(1)) u_small (
    .clk_in(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(s_in_mode),
    .in_key(s_in_key), .in_block(s_in_block), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_block(s_out_block), .busy(s_busy)
  );

  feistel_iter_core u_dflt (
    .clk_in(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_mode(d_in_mode),
    .in_key(d_in_key), .in_block(d_in_block), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_block(d_out_block), .busy(d_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
  endfunction

  // Reference cipher at the default configuration (32-bit halves, 16 rounds, FROT=3, KROT=1).
  function automatic logic [63:0] model(input logic dec, input logic [31:0] key, input logic [63:0] blk);
    logic [31:0] l, r, k, t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      k = rotl32(key, dec ? (15 - i) : i);
      t = l ^ (rotl32(r ^ k, 3) + k);
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  task automatic run_s(input logic mode, input logic [7:0] key, input logic [15:0] blk, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    s_in_valid = 1'b1; s_in_mode = mode; s_in_key = key; s_in_block = blk;
    exp_s_q.push_back(exp);
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("s_latency", 64'(lat), 64'd2);
    check("s_block", 64'(s_out_block), 64'(exp_s_q.pop_front()));
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("s_idle_flags", 64'({s_in_ready, s_out_valid, s_busy}), 64'd4);
  endtask

  task automatic run_d(input logic mode, input logic [31:0] key, input logic [63:0] blk,
                       input int hold, output logic [63:0] res);
    int lat;
    logic ready_bad, busy_bad, stable_bad;
    logic [63:0] held;
    @(negedge clk);
    d_in_valid = 1'b1; d_in_mode = mode; d_in_key = key; d_in_block = blk;
    exp_d_q.push_back(model(mode, key, blk));
    @(negedge clk);
    d_in_valid = 1'b0;
    lat = 1; ready_bad = 1'b0; busy_bad = 1'b0;
    while (!d_out_valid && lat < 40) begin
      ready_bad |= d_in_ready;
      busy_bad  |= !d_busy;
      @(negedge clk);
      lat++;
    end
    ready_bad |= d_in_ready;
    check("d_latency", 64'(lat), 64'd17);
    check("d_ready_low", 64'(ready_bad), 64'd0);
    check("d_busy_run", 64'(busy_bad), 64'd0);
    held = d_out_block;
    stable_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      d_in_valid = ((i % 2) == 0);
      d_in_block = {$urandom, $urandom};
      @(negedge clk);
      stable_bad |= !d_out_valid || d_in_ready || (d_out_block !== held);
    end
    d_in_valid = 1'b0;
    if (hold > 0) check("d_backpressure", 64'(stable_bad), 64'd0);
    res = d_out_block;
    check("d_block", d_out_block, exp_d_q.pop_front());
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;
    check("d_idle_flags", 64'({d_in_ready, d_out_valid, d_busy}), 64'd4);
`ifdef FEISTEL_ZEROIZE_EN
    check("d_zeroize", d_out_block, 64'd0);
`else
    check("d_retain", d_out_block, res);
`endif
  endtask

  initial begin
    logic [63:0] y, z, x;
    logic [31:0] key;
    rst = 1'b1;
    s_in_valid = 1'b0; s_in_mode = 1'b0; s_in_key = 8'd0; s_in_block = 16'd0; s_out_ready = 1'b0;
    d_in_valid = 1'b0; d_in_mode = 1'b0; d_in_key = 32'd0; d_in_block = 64'd0; d_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("s_reset", 64'({s_in_ready, s_out_valid, s_busy, s_out_block}), {45'd0, 3'b100, 16'd0});
    check("d_reset", 64'({d_in_ready, d_out_valid, d_busy}), 64'd4);
    check("d_reset_blk", d_out_block, 64'd0);
    rst = 1'b0;

    run_s(1'b0, 8'h00, 16'h0102, 16'h1102);
    run_s(1'b0, 8'h0F, 16'h0000, 16'h8700);
    run_s(1'b1, 8'h0F, 16'h8700, 16'h0000);

    run_d(1'b0, 32'h0123_4567, 64'h89AB_CDEF_FEDC_BA98, 10, y);
    run_d(1'b1, 32'h0123_4567, y, 0, z);
    check("d_bp_roundtrip", z, 64'h89AB_CDEF_FEDC_BA98);

    // Abort at round 5, then confirm a clean restart.
    @(negedge clk);
    d_in_valid = 1'b1; d_in_mode = 1'b0; d_in_key = 32'hDEAD_BEEF; d_in_block = 64'h1111_2222_3333_4444;
    @(negedge clk);
    d_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("d_busy_mid", 64'(d_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("d_rst_flags", 64'({d_in_ready, d_out_valid, d_busy}), 64'd4);
    check("d_rst_blk", d_out_block, 64'd0);
    rst = 1'b0;
    run_d(1'b0, 32'hDEAD_BEEF, 64'h1111_2222_3333_4444, 0, y);

    for (int n = 0; n < 200; n++) begin
      key = $urandom;
      x   = {$urandom, $urandom};
      run_d(1'b0, key, x, 0, y);
      run_d(1'b1, key, y, 0, z);
      check("d_roundtrip", z, x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/feistel_iter_core.md
Name: feistel_iter_core

Overview:
- Parametrised iterative Feistel block-cipher engine.
- Successor to the fixed single-purpose DES instance in the board top.
- Generalised in half-block width, round count and rotation constants; adds encrypt/decrypt mode and valid/ready handshakes on input and output.
- Instantiated in top between the Xmega interconnect capture logic and the LED/SEG readout.

Parameters:
- HALF_W, 32, width of each Feistel half; block width is 2*HALF_W and key width is HALF_W.
- ROUNDS, 16, number of rounds; legal range is ROUNDS >= 1 (elaboration error otherwise).
- FROT, 3, left-rotate amount inside the round function F (taken mod HALF_W).
- KROT, 1, per-round key-schedule rotate step (taken mod HALF_W).

Ports:
- clk_in  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input block and key presented.
- in_ready  output  1  core can accept an input block.
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled at input accept.
- in_key  input  HALF_W  cipher key; sampled at input accept.
- in_block  input  2*HALF_W  {L0,R0}; sampled at input accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_block  output  2*HALF_W  result block.
- busy  output  1  high while in RUN.

Behaviour:
- One clock, clk_in; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_block=0, round counter=0. Internal L/R/key registers are cleared to 0.
- Reset asserted mid-operation (RUN or DONE) aborts the operation on that edge; no partial result is ever presented.
- Round function: F(x,k) = rotl(x ^ k, FROT) + k, mod 2^HALF_W.
- Key schedule: K_i = rotl(key, (i*KROT) mod HALF_W), for i = 0..ROUNDS-1.
- Round r uses K_r when encrypting and K_(ROUNDS-1-r) when decrypting.
- Round step: L' = R; R' = L ^ F(R, K). Result = {R_final, L_final} (last swap undone). With this definition, decrypt(encrypt(x)) == x for any key.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture mode, key, L and R; clear counter; go to RUN.
  - RUN: busy=1, in_ready=0. One round per cycle, counter increments. After round ROUNDS-1, register out_block and go to DONE.
  - DONE: out_valid=1, out_block held stable, in_ready=0. On out_ready, go to IDLE.
- Latency: out_valid rises exactly ROUNDS+1 cycles after the accept edge.
- Throughput: one block per ROUNDS+2 cycles with out_ready held high.
- Input and output do not overlap: a new accept is possible only on the cycle after the out handshake.
- Input signals are ignored outside IDLE. out_ready is ignored outside DONE.
- Counter width is $clog2(ROUNDS+1). ROUNDS=1 is legal: RUN lasts one cycle.

Optional Feature:
- Macro: FEISTEL_ZEROIZE_EN.
- Defined: on the out handshake edge, the key, L and R registers are cleared to 0, and out_block is cleared to 0 on the following edge. out_block reads 0 whenever out_valid=0.
- Undefined: those registers keep their last values, and out_block holds the last result until the next DONE.

Decomposition:
- feistel_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - a rotl function parametrised by width;
  - localparam BLK_W = 2*HALF_W, computed from the HALF_W passed in.
- One combinational sub-module, feistel_round: inputs L, R, base key, round index and mode; outputs L', R'. It contains the key selection and F.

Test Plan:
- Encrypt known answer: HALF_W=8, ROUNDS=1, FROT=3, KROT=1, key=0x00, block=0x0102, mode=0 -> out_block=0x1102, out_valid 2 cycles after accept.
- Keyed encrypt and inverse: key=0x0F, block=0x0000, mode=0 -> 0x8700. Then block=0x8700, mode=1 -> 0x0000.
- Round trip at defaults: 200 random key/block pairs, encrypt then decrypt -> original block every time. in_ready=0 throughout RUN/DONE; latency is 17 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_block stay stable, and in_valid pulses are ignored. Raise out_ready -> next cycle IDLE, in_ready=1.
- Reset mid-RUN: assert rst at round 5 -> next edge out_valid=0, in_ready=1, busy=0, out_block=0. A fresh block then completes correctly.
- FEISTEL_ZEROIZE_EN: after the out handshake, out_block=0 one cycle later. Without the macro, out_block retains the result.
